// File: rtl/map_draw_pkg.sv
// Shared definitions for the map redraw engine and the game-state controller:
// game state codes, background image indices, engine states and default geometry.
package map_draw_pkg;

  localparam logic [3:0] DRAW_INITIAL  = 4'd0;
  localparam logic [3:0] WAIT_INITIAL  = 4'd1;
  localparam logic [3:0] DRAW_LEVEL1   = 4'd2;
  localparam logic [3:0] WAIT_LEVEL1   = 4'd3;
  localparam logic [3:0] DRAW_LEVEL2   = 4'd4;
  localparam logic [3:0] WAIT_LEVEL2   = 4'd5;
  localparam logic [3:0] DRAW_LEVEL3   = 4'd6;
  localparam logic [3:0] WAIT_LEVEL3   = 4'd7;
  localparam logic [3:0] DRAW_LOST     = 4'd8;
  localparam logic [3:0] WAIT_LOST     = 4'd9;
  localparam logic [3:0] RETRY_LOST    = 4'd10;
  localparam logic [3:0] FINISHED_GAME = 4'd11;

  localparam logic [2:0] MAP_INITIAL  = 3'd0;
  localparam logic [2:0] MAP_LEVEL1   = 3'd1;
  localparam logic [2:0] MAP_LEVEL2   = 3'd2;
  localparam logic [2:0] MAP_LEVEL3   = 3'd3;
  localparam logic [2:0] MAP_LOST     = 3'd4;
  localparam logic [2:0] MAP_FINISHED = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } eng_state_t;

  localparam int DEF_H_RES    = 320;
  localparam int DEF_V_RES    = 240;
  localparam int DEF_COLOUR_W = 9;
  localparam int DEF_ADDR_W   = 17;

  // Unassigned codes (12..15) fall back to the initial background.
  function automatic logic [2:0] map_select(input logic [3:0] gs);
    case (gs)
      DRAW_INITIAL, WAIT_INITIAL:       map_select = MAP_INITIAL;
      DRAW_LEVEL1, WAIT_LEVEL1:         map_select = MAP_LEVEL1;
      DRAW_LEVEL2, WAIT_LEVEL2:         map_select = MAP_LEVEL2;
      DRAW_LEVEL3, WAIT_LEVEL3:         map_select = MAP_LEVEL3;
      DRAW_LOST, WAIT_LOST, RETRY_LOST: map_select = MAP_LOST;
      FINISHED_GAME:                    map_select = MAP_FINISHED;
      default:                          map_select = MAP_INITIAL;
    endcase
  endfunction

endpackage

// File: rtl/map_scan_counter.sv
// Raster scan counter: x/y position and linear ROM address for a row-major
// sweep, with a flag marking the final pixel of the frame.
module map_scan_counter
  import map_draw_pkg::*;
#(
  parameter int H_RES  = DEF_H_RES,
  parameter int V_RES  = DEF_V_RES,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              advance,
  output logic [8:0]        x,
  output logic [7:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [8:0] X_LAST = 9'(H_RES - 1);
  localparam logic [7:0] Y_LAST = 8'(V_RES - 1);

  assign last = (x == X_LAST) && (y == Y_LAST);

  // Row-major order makes the address a plain +1 per pixel; it holds at the
  // final pixel so it never leaves the frame.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (start) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (advance && !last) begin
      addr <= addr + ADDR_W'(1);
      if (x == X_LAST) begin
        x <= '0;
        y <= y + 8'd1;
      end else begin
        x <= x + 9'd1;
      end
    end
  end

endmodule

// File: rtl/map_redraw_engine.sv
// Redraws the full-screen background on a drawMap request and answers with
// doneRedraw. Optional macro MAP_SKIP_TRANSPARENT_EN suppresses key-colour pixels.
module map_redraw_engine
  import map_draw_pkg::*;
#(
  parameter int                  H_RES         = DEF_H_RES,
  parameter int                  V_RES         = DEF_V_RES,
  parameter int                  COLOUR_W      = DEF_COLOUR_W,
  parameter int                  ADDR_W        = DEF_ADDR_W,
  parameter logic [COLOUR_W-1:0] TRANSP_COLOUR = COLOUR_W'(9'h1FF)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                drawMap,
  input  logic [3:0]          gameState,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [2:0]          rom_sel,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic [8:0]          x,
  output logic [7:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                doneRedraw
);

`ifdef MAP_SKIP_TRANSPARENT_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  eng_state_t        state, state_nxt;
  logic [3:0]        st_q;
  logic              start, advance, last;
  logic [8:0]        cnt_x;
  logic [7:0]        cnt_y;
  logic [ADDR_W-1:0] cnt_addr;
  logic              vld_p1;
  logic [8:0]        x_p1;
  logic [7:0]        y_p1;

  map_scan_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .ADDR_W(ADDR_W)
  ) u_scan (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .advance(advance),
    .x      (cnt_x),
    .y      (cnt_y),
    .addr   (cnt_addr),
    .last   (last)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Once started, a sweep ignores drawMap and gameState until DONE.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (drawMap) begin
          start     = 1'b1;
          state_nxt = DRAW;
        end
      end
      DRAW: begin
        advance = 1'b1;
        if (last) state_nxt = FLUSH;
      end
      FLUSH: state_nxt = DONE;
      DONE: begin
        if (gameState != st_q) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      st_q    <= '0;
      rom_sel <= '0;
    end else if (start) begin
      st_q    <= gameState;
      rom_sel <= map_select(gameState);
    end
  end

  // Stage p0 -> p1: position follows its address by the one-cycle ROM latency.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_p1 <= 1'b0;
      x_p1   <= '0;
      y_p1   <= '0;
    end else begin
      vld_p1 <= (state == DRAW);
      if (state == DRAW) begin
        x_p1 <= cnt_x;
        y_p1 <= cnt_y;
      end
    end
  end

  // The ROM output register is the colour stage, so colour is taken straight
  // from rom_data and qualified by the pipeline valid.
  assign rom_addr   = cnt_addr;
  assign x          = x_p1;
  assign y          = y_p1;
  assign colour     = vld_p1 ? rom_data : '0;
  assign plot       = vld_p1 && !(SKIP_EN && (rom_data == TRANSP_COLOUR));
  assign doneRedraw = (state == DONE);

endmodule

// File: tb/tb_map_redraw_engine.sv
// Scoreboard bench for map_redraw_engine on a 4x3 screen with a model ROM.
`timescale 1ns/1ps
module tb_map_redraw_engine;

  localparam int H = 4;
  localparam int V = 3;
  localparam int CW = 9;
  localparam int AW = 4;
  localparam int NPIX = H * V;
`ifdef MAP_SKIP_TRANSPARENT_EN
  localparam int NKEY_PLOTS = 9;
`else
  localparam int NKEY_PLOTS = 12;
`endif

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          drawMap = 1'b0;
  logic [3:0]    gameState = 4'd0;
  logic [CW-1:0] rom_data = '0;
  logic [2:0]    rom_sel;
  logic [AW-1:0] rom_addr;
  logic [8:0]    x;
  logic [7:0]    y;
  logic [CW-1:0] colour;
  logic          plot;
  logic          doneRedraw;

  map_redraw_engine #(
    .H_RES(H), .V_RES(V), .COLOUR_W(CW), .ADDR_W(AW), .TRANSP_COLOUR(9'h1FF)
  ) dut (
    .clock(clock), .resetn(resetn), .drawMap(drawMap), .gameState(gameState),
    .rom_data(rom_data), .rom_sel(rom_sel), .rom_addr(rom_addr),
    .x(x), .y(y), .colour(colour), .plot(plot), .doneRedraw(doneRedraw)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [8:0]    x;
    logic [7:0]    y;
    logic [CW-1:0] c;
    logic [2:0]    sel;
  } pix_t;

  pix_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   plots = 0;
  int   first_plot = -1;
  int   last_plot = -1;
  bit   key_mode = 1'b0;

  function automatic logic [CW-1:0] rom_img(input logic [2:0] sel, input int addr, input bit key);
    if (key && sel == 3'd0 && (addr == 2 || addr == 5 || addr == 9)) return 9'h1FF;
    return {sel, 2'b01, 4'(addr)};
  endfunction

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rom_data <= rom_img(rom_sel, int'(rom_addr), key_mode);
  end

  always @(negedge clock) begin
    pix_t e;
    if (resetn === 1'b1 && plot === 1'b1) begin
      plots = plots + 1;
      if (first_plot < 0) first_plot = cyc;
      last_plot = cyc;
      checks = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_plot: got (%0d,%0d) colour=%h, required no plot", x, y, colour);
      end else begin
        e = sb.pop_front();
        if (x !== e.x || y !== e.y || colour !== e.c || rom_sel !== e.sel) begin
          errors = errors + 1;
          $display("FAIL pixel: got (%0d,%0d) colour=%h sel=%0d, required (%0d,%0d) colour=%h sel=%0d",
                   x, y, colour, rom_sel, e.x, e.y, e.c, e.sel);
        end
      end
    end
  end

  // Pulses drawMap for one cycle and loads the scoreboard with the expected raster.
  task automatic request(input logic [3:0] gs, input logic [2:0] sel, output int c0);
    @(negedge clock); #1;
    gameState = gs;
    drawMap   = 1'b1;
    c0        = cyc;
    plots = 0; first_plot = -1; last_plot = -1;
    for (int i = 0; i < NPIX; i++) begin
      pix_t e;
      e.x = 9'(i % H); e.y = 8'(i / H); e.sel = sel; e.c = rom_img(sel, i, key_mode);
`ifdef MAP_SKIP_TRANSPARENT_EN
      if (e.c != 9'h1FF) sb.push_back(e);
`else
      sb.push_back(e);
`endif
    end
    @(negedge clock); #1;
    drawMap = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    int n;
    n = 0; dc = -1;
    while (doneRedraw !== 1'b1 && n < 200) begin
      @(negedge clock); #1;
      n++;
    end
    checks++;
    if (doneRedraw !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: doneRedraw=%b after %0d cycles, required 1", doneRedraw, n);
    end else dc = cyc;
  endtask

  task automatic leave_done(input logic [3:0] gs);
    @(negedge clock); #1;
    gameState = gs;
    @(negedge clock); #1;
    checks++;
    if (doneRedraw !== 1'b0 || plot !== 1'b0) begin
      errors++;
      $display("FAIL leave_done: doneRedraw=%b plot=%b, required 0 0", doneRedraw, plot);
    end
  endtask

  task automatic run_sweep(input logic [3:0] gs, input logic [2:0] sel, input int nexp);
    int c0, dc;
    request(gs, sel, c0);
    wait_done(dc);
    checks++;
    if (plots !== nexp || sb.size() != 0) begin
      errors++;
      $display("FAIL sweep_count gs=%0d: got %0d plots (%0d left), required %0d", gs, plots, sb.size(), nexp);
    end
    checks++;
    if (first_plot !== c0 + 2 || last_plot !== c0 + 13) begin
      errors++;
      $display("FAIL sweep_timing gs=%0d: first/last plot %0d/%0d, required %0d/%0d",
               gs, first_plot - c0, last_plot - c0, 2, 13);
    end
    checks++;
    if (dc !== c0 + 14) begin
      errors++;
      $display("FAIL done_timing gs=%0d: done at +%0d, required +14", gs, dc - c0);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0; drawMap = 1'b0; gameState = 4'd0;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if ({x, y} !== 17'd0) begin
      errors++; $display("FAIL reset_xy: got x=%0d y=%0d, required 0 0", x, y);
    end
    checks++;
    if ({colour, plot, doneRedraw} !== '0) begin
      errors++; $display("FAIL reset_pix: colour=%h plot=%b done=%b, required 0", colour, plot, doneRedraw);
    end
    checks++;
    if ({rom_addr, rom_sel} !== '0) begin
      errors++; $display("FAIL reset_rom: addr=%0d sel=%0d, required 0 0", rom_addr, rom_sel);
    end
    @(negedge clock); #1;
    resetn = 1'b1;
  endtask

  task automatic test_basic;
    run_sweep(4'd0, 3'd0, 12);
    leave_done(4'd15);
  endtask

  task automatic test_hold;
    int bad;
    run_sweep(4'd2, 3'd1, 12);
    bad = 0;
    repeat (20) begin
      @(negedge clock); #1;
      if (doneRedraw !== 1'b1 || plot !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL done_hold: %0d cycles with done=0 or plot=1, required 0", bad);
    end
    leave_done(4'd3);
    repeat (5) @(negedge clock);
    #1;
    checks++;
    if (plots !== 12 || doneRedraw !== 1'b0) begin
      errors++; $display("FAIL idle_quiet: plots=%0d done=%b, required 12 0", plots, doneRedraw);
    end
  endtask

  task automatic test_map_sel;
    run_sweep(4'd4, 3'd2, 12);
    leave_done(4'd15);
    run_sweep(4'd9, 3'd4, 12);
    leave_done(4'd15);
    run_sweep(4'd11, 3'd5, 12);
    leave_done(4'd15);
  endtask

  task automatic test_reset_mid;
    int c0, n;
    request(4'd0, 3'd0, c0);
    n = 0;
    while (plots < 6 && n < 50) begin
      @(negedge clock); #2;
      n++;
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({x, y, colour, plot, doneRedraw, rom_addr, rom_sel} !== '0) begin
      errors++;
      $display("FAIL mid_reset: x=%0d y=%0d colour=%h plot=%b done=%b addr=%0d sel=%0d, required all 0 (plots seen %0d)",
               x, y, colour, plot, doneRedraw, rom_addr, rom_sel, plots);
    end
    sb.delete();
    @(negedge clock); #1;
    resetn = 1'b1;
    run_sweep(4'd0, 3'd0, 12);
    leave_done(4'd15);
  endtask

  task automatic test_atomic;
    int c0, dc;
    request(4'd6, 3'd3, c0);
    drawMap = 1'b1; gameState = 4'd0;
    repeat (3) @(negedge clock);
    #1;
    drawMap = 1'b0; gameState = 4'd9;
    repeat (2) @(negedge clock);
    #1;
    gameState = 4'd6;
    wait_done(dc);
    checks++;
    if (plots !== 12 || sb.size() != 0 || dc !== c0 + 14) begin
      errors++;
      $display("FAIL atomic: plots=%0d left=%0d done at +%0d, required 12 0 +14", plots, sb.size(), dc - c0);
    end
    leave_done(4'd15);
  endtask

  task automatic test_transparent;
    key_mode = 1'b1;
    run_sweep(4'd0, 3'd0, NKEY_PLOTS);
    key_mode = 1'b0;
    leave_done(4'd15);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_map_sel();
    test_reset_mid();
    test_atomic();
    test_transparent();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/map_redraw_engine.md
Name: map_redraw_engine

Overview:
- Responder side of the drawMap/doneRedraw handshake issued by the game-state controller.
- On request, latches the current gameState and selects the matching background image.
- Sweeps every pixel of the screen, reading colour from a synchronous background ROM and driving the VGA adapter write port (x, y, colour, plot).
- Raises doneRedraw and holds it until the controller moves to a different gameState.

Parameters:
- H_RES, 320: pixels per row; x counts 0..H_RES-1.
- V_RES, 240: rows; y counts 0..V_RES-1.
- COLOUR_W, 9: colour width, 3 bits per channel.
- ADDR_W, 17: ROM address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- TRANSP_COLOUR, 9'h1FF: key colour, used only with the optional feature.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- drawMap  in  1  redraw request from the game-state controller. Level signal; it drops once doneRedraw rises.
- gameState  in  4  current game state code.
- rom_data  in  COLOUR_W  ROM read data. Valid one cycle after rom_addr/rom_sel.
- rom_sel  out  3  background image index.
- rom_addr  out  ADDR_W  pixel address, y*H_RES + x.
- x  out  9  VGA write x.
- y  out  8  VGA write y.
- colour  out  COLOUR_W  VGA write colour.
- plot  out  1  VGA write enable, one pixel per cycle.
- doneRedraw  out  1  redraw complete.

Behaviour:
- Reset (async, resetn=0): state IDLE. All outputs 0: x, y, colour, plot, doneRedraw, rom_addr, rom_sel. Internal counters 0. A reset mid-sweep aborts the sweep immediately; a new request restarts from pixel 0.
- State IDLE:
  - drawMap=1 sampled at edge N: latch gameState into st_q and set rom_sel from the map table; go to DRAW.
  - The counter starts at (0,0) and rom_addr=0 is driven during cycle N+1.
- Map table (gameState -> rom_sel):
  - 0,1 -> 0
  - 2,3 -> 1
  - 4,5 -> 2
  - 6,7 -> 3
  - 8,9,10 -> 4
  - 11 -> 5
  - 12..15 -> 0
- State DRAW:
  - Issues one address per cycle.
  - x increments; at x=H_RES-1 it wraps to 0 and y increments.
  - rom_addr is a registered y*H_RES+x, maintained incrementally with no multiplier.
  - Pipeline: x, y, colour and plot are registered one cycle after the address they correspond to. The first plot=1 for pixel (0,0) appears in cycle N+2.
  - After the address for (H_RES-1, V_RES-1) is issued, go to FLUSH.
- State FLUSH:
  - Lasts one cycle and emits the final pixel.
  - plot=0 from the next cycle; doneRedraw=1 in the cycle after the last plot; go to DONE.
  - Total: exactly H_RES*V_RES plot pulses per request.
- State DONE:
  - doneRedraw is held at 1 and plot=0.
  - When gameState != st_q: doneRedraw=0 next cycle, go to IDLE.
  - gameState staying equal (e.g. FINISHED_GAME) keeps doneRedraw=1 indefinitely.
- Simultaneous events and corner cases:
  - drawMap dropping during DRAW is ignored; a sweep is atomic.
  - gameState changing during DRAW is ignored; st_q is not updated and the sweep completes.
  - If drawMap=1 in IDLE after returning from DONE, a new sweep starts with the new state.
  - A drawMap pulse of a single cycle suffices to start a sweep.
- Widths:
  - x zero-extended to 9 bits and y to 8 bits.
  - rom_addr never exceeds H_RES*V_RES-1.

Optional Feature:
- Macro: MAP_SKIP_TRANSPARENT_EN.
- Defined: pixels whose rom_data == TRANSP_COLOUR produce plot=0. Their x/y still advance, so sweep timing and doneRedraw timing are unchanged.
- Undefined: every pixel is plotted regardless of colour.

Decomposition:
- Package map_draw_pkg holds:
  - game state codes DRAW_INITIAL=0 .. FINISHED_GAME=11, shared with the game-state controller;
  - map index constants MAP_INITIAL..MAP_FINISHED;
  - the gameState->rom_sel mapping function;
  - engine state encodings IDLE/DRAW/FLUSH/DONE;
  - default resolution constants.
- Sub-module map_scan_counter contains the x/y/address counters with wrap and last-pixel flag. Inputs are start and advance; outputs are x, y, addr and last.

Test Plan:
- H_RES=4, V_RES=3, gameState=0, drawMap 1-cycle pulse -> 12 plot pulses in 12 consecutive cycles starting 2 cycles after the pulse. Order (0,0),(1,0)..(3,2). colour equals model ROM data. doneRedraw=1 one cycle after the last plot.
- Hold gameState=2 after done -> doneRedraw stays 1. Change gameState to 3 -> doneRedraw=0 next cycle, IDLE, no plots.
- Map selection: gameState 4, 9 and 11 -> rom_sel 2, 4 and 5 respectively during the sweep. Colours match the corresponding ROM images.
- Drive resetn=0 at pixel 6 mid-sweep -> all outputs 0 immediately. A fresh request restarts at (0,0) and delivers 12 plots.
- gameState toggled and drawMap dropped mid-sweep -> sweep completes with the original rom_sel and exactly 12 plots.
- With MAP_SKIP_TRANSPARENT_EN, ROM holding 3 pixels = 9'h1FF -> 9 plot pulses. doneRedraw timing is identical to the feature-off run.
